// File: rtl/exe_mul_ctrl.sv
// Iterative shift-and-add multiplier controller for the EXE stage.
// Stalls the pipeline while the product is accumulated, one multiplier bit per cycle.
module exe_mul_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] val_rn,
   input  logic [31:0] val_rm,
   input  logic        s_bit,
   input  logic [3:0]  sr,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] mul_result,
   output logic [3:0]  status,
   output logic        status_wr
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        s_q, s_d;
   logic        c_q, c_d;
   logic        v_q, v_d;

   logic [31:0] mplier_shift;
   logic [31:0] acc_add;

   assign mplier_shift = mplier_q >> 1;
   assign acc_add      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) state_d = StRun;
         end
         StRun: begin
            if (flush) begin
               state_d = StIdle;
            end else if (mplier_shift == 32'd0 || cnt_q == 5'd31) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      s_d      = s_q;
      c_d      = c_q;
      v_d      = v_q;
      if (state_q == StIdle && start && !flush) begin
         mcand_d  = val_rn;
         mplier_d = val_rm;
         acc_d    = 32'd0;
         cnt_d    = 5'd0;
         s_d      = s_bit;
         c_d      = sr[1];
         v_d      = sr[0];
      end else if (state_q == StRun && !flush) begin
         acc_d    = acc_add;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_shift;
         cnt_d    = cnt_q + 5'd1;
         // Capture on the last RUN edge so mul_result equals acc throughout DONE
         if (state_d == StDone) result_d = acc_add;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= 32'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         cnt_q    <= 5'd0;
         result_q <= 32'd0;
         s_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         s_q      <= s_d;
         c_q      <= c_d;
         v_q      <= v_d;
      end
   end

   // Outputs; reset overrides state so an abort mid-RUN shows idle values at once
   always_comb begin
      stall     = 1'b0;
      done      = 1'b0;
      status    = 4'b0100;
      status_wr = 1'b0;
      if (!rst) begin
         stall     = (state_q == StIdle && start && !flush) || (state_q == StRun);
         done      = (state_q == StDone);
         status    = {acc_q[31], (acc_q == 32'd0), c_q, v_q};
         status_wr = done && s_q;
      end
   end

   assign mul_result = result_q;

endmodule

// File: tb/tb_exe_mul_ctrl.sv
// Directed bench for exe_mul_ctrl: hand-computed products, status, timing and abort cases.
module tb_exe_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] val_rn;
   logic [31:0] val_rm;
   logic        s_bit;
   logic [3:0]  sr;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] mul_result;
   logic [3:0]  status;
   logic        status_wr;

   int n_vec = 0;
   int n_err = 0;

   exe_mul_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .val_rn     (val_rn),
      .val_rm     (val_rm),
      .s_bit      (s_bit),
      .sr         (sr),
      .flush      (flush),
      .stall      (stall),
      .done       (done),
      .mul_result (mul_result),
      .status     (status),
      .status_wr  (status_wr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full operation: checks stall/done per cycle, result and status in DONE,
   // and that a start held during DONE is ignored.
   task automatic run_mul(input string tag, input logic [31:0] rn, input logic [31:0] rm,
                          input logic s, input logic [3:0] srv, input int n,
                          input logic [31:0] exp_res, input logic [3:0] exp_st,
                          input logic exp_wr);
      start  = 1'b1;
      val_rn = rn;
      val_rm = rm;
      s_bit  = s;
      sr     = srv;
      #1;
      chk({tag, " stall c0"}, 32'(stall), 32'd1);
      tick();
      start  = 1'b0;
      val_rn = 32'hdead_beef;
      val_rm = 32'hffff_ffff;
      s_bit  = ~s;
      sr     = ~srv;
      #1;
      for (int i = 1; i <= n; i++) begin
         if (i == 1 || i == n) begin
            chk({tag, " run stall"}, 32'(stall), 32'd1);
            chk({tag, " run done"}, 32'(done), 32'd0);
         end
         tick();
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " done stall"}, 32'(stall), 32'd0);
      chk({tag, " result"}, mul_result, exp_res);
      chk({tag, " status"}, 32'(status), 32'(exp_st));
      chk({tag, " status_wr"}, 32'(status_wr), 32'(exp_wr));
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk({tag, " idle after done stall"}, 32'(stall), 32'd0);
      chk({tag, " done pulse width"}, 32'(done), 32'd0);
      chk({tag, " result hold"}, mul_result, exp_res);
   endtask

   initial begin
      bit saw_done;
      rst    = 1'b1;
      start  = 1'b1;
      flush  = 1'b0;
      val_rn = 32'd3;
      val_rm = 32'd5;
      s_bit  = 1'b1;
      sr     = 4'b0011;
      tick();
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst status_wr", 32'(status_wr), 32'd0);
      chk("rst status", 32'(status), 32'h4);
      tick();
      start = 1'b0;
      rst   = 1'b0;
      #1;
      chk("rst mul_result", mul_result, 32'd0);
      chk("idle stall", 32'(stall), 32'd0);

      // start masked by flush in IDLE
      start = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush idle stall", 32'(stall), 32'd0);
      tick();
      start = 1'b0;
      flush = 1'b0;
      #1;
      chk("flush idle no run", 32'(stall), 32'd0);

      run_mul("3x5", 32'd3, 32'd5, 1'b1, 4'b0010, 3, 32'd15, 4'b0010, 1'b1);
      run_mul("ffxff", 32'hffff_ffff, 32'hffff_ffff, 1'b1, 4'b0000, 32, 32'h1, 4'b0000, 1'b1);
      run_mul("7x0", 32'd7, 32'd0, 1'b1, 4'b0000, 1, 32'd0, 4'b0100, 1'b1);
      run_mul("1x8000", 32'd1, 32'h8000_0000, 1'b0, 4'b0011, 32, 32'h8000_0000, 4'b1011,
              1'b0);
      run_mul("shift8", 32'h1234_5678, 32'h100, 1'b1, 4'b0001, 9, 32'h3456_7800, 4'b0001,
              1'b1);

      // Reset during RUN cycle 10 of a 32-cycle op
      start  = 1'b1;
      val_rn = 32'hffff_ffff;
      val_rm = 32'hffff_ffff;
      s_bit  = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      chk("pre-rst stall", 32'(stall), 32'd1);
      rst = 1'b1;
      flush = 1'b1;
      start = 1'b1;
      #1;
      chk("mid rst stall", 32'(stall), 32'd0);
      chk("mid rst status", 32'(status), 32'h4);
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      start = 1'b0;
      #1;
      chk("post rst stall", 32'(stall), 32'd0);
      chk("post rst mul_result", mul_result, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done || stall) saw_done = 1'b1;
         tick();
      end
      chk("post rst no done", 32'(saw_done), 32'd0);

      // Flush in RUN cycle 2, then a fresh op
      run_mul("pre-flush", 32'd3, 32'd5, 1'b1, 4'b0010, 3, 32'd15, 4'b0010, 1'b1);
      start  = 1'b1;
      val_rn = 32'h1234_5678;
      val_rm = 32'h100;
      tick();
      start = 1'b0;
      tick();
      flush = 1'b1;
      #1;
      chk("flush run stall", 32'(stall), 32'd1);
      tick();
      flush = 1'b0;
      #1;
      chk("post flush stall", 32'(stall), 32'd0);
      chk("post flush result", mul_result, 32'd15);
      saw_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (done || status_wr) saw_done = 1'b1;
         tick();
      end
      chk("post flush no done", 32'(saw_done), 32'd0);
      chk("post flush result hold", mul_result, 32'd15);
      run_mul("6x7", 32'd6, 32'd7, 1'b1, 4'b0000, 3, 32'd42, 4'b0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
